instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 29 ++
 rtl/instruction_fetch_unit_pc_register.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the immediate unit.
//   - fetch_state_e : fetch FSM state encoding (BOOT, FETCH, FAULT)
//   - IFU_NOP_INSTR : bubble instruction (addi x0,x0,0)
//   - OPC_*         : RV32I major opcodes that the immediate unit decodes
//   - is_misaligned : true when an address is not on a 32-bit word boundary
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_I       = 7'h13;
    localparam logic [6:0] OPC_U_LUI   = 7'h37;
    localparam logic [6:0] OPC_U_AUIPC = 7'h17;
    localparam logic [6:0] OPC_S       = 7'h23;
    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_B       = 7'h63;
    localparam logic [6:0] OPC_J       = 7'h6F;
    localparam logic [6:0] OPC_JALR    = 7'h67;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Fetch program counter register.
//   clk, reset : clock, synchronous active-high reset (loads RESET_PC)
//   load       : load load_pc (takes priority over inc)
//   load_pc    : new fetch address
//   inc        : advance to the next word (pc + 4, wraps modulo 2^32)
//   pc         : current fetch address
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory and holds
// the fetched word in the IF/ID register for decode and the immediate unit.
//   clk, reset         : clock, synchronous active-high reset
//   stall_i            : decode cannot take a new instruction this cycle
//   redirect_i/_pc_i   : taken branch/jump from execute, flush and refetch
//   imem_req_o/addr_o  : fetch request and address to instruction memory
//   imem_ready_i       : memory accepts the request, data returned same cycle
//   imem_rdata_i       : fetched instruction word
//   inst_valid_o       : IF/ID register holds a real instruction
//   Instruction_bus_o  : IF/ID instruction word (NOP when not valid)
//   op_o               : Instruction_bus_o[6:0]
//   pc_o               : address of the instruction in Instruction_bus_o
//   fault_o            : sticky misaligned-redirect fault
//   inst_count_o       : instructions accepted from memory (wraps)
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] Instruction_bus_o,
    output logic [6:0]  op_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [31:0] inst_count_o
);

    fetch_state_e state, state_nxt;

    logic [31:0] fetch_pc;
    logic        redir_live;
    logic        redir_bad;
    logic        accept;

    // IF/ID register
    logic        vld_p1;
    logic [31:0] inst_p1;
    logic [6:0]  op_p1;
    logic [31:0] pc_p1;
    logic [31:0] count_p1;

    // Redirects are ignored once faulted; a misaligned target is never loaded.
    assign redir_live = redirect_i && (state != ST_FAULT);
    assign redir_bad  = redir_live && is_misaligned(redirect_pc_i);

    // A request goes out when the register is free or being drained this cycle.
    assign imem_req_o  = (state == ST_FETCH) && !redirect_i && (!vld_p1 || !stall_i);
    assign imem_addr_o = fetch_pc;
    assign accept      = imem_req_o && imem_ready_i;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .reset   (reset),
        .load    (redir_live && !redir_bad),
        .load_pc (redirect_pc_i),
        .inc     (accept),
        .pc      (fetch_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:  state_nxt = redir_bad ? ST_FAULT : ST_FETCH;
            ST_FETCH: if (redir_bad) state_nxt = ST_FAULT;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_BOOT;
        endcase
    end

    // ---- stage p1: IF/ID register ----
    // Priority: reset, fault hold, redirect flush, accept, stall hold, bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            inst_p1 <= NOP_INSTR;
            op_p1   <= NOP_INSTR[6:0];
            pc_p1   <= RESET_PC;
        end else if (state == ST_FAULT) begin
            vld_p1  <= vld_p1;
        end else if (redir_live) begin
            vld_p1  <= 1'b0;
            inst_p1 <= NOP_INSTR;
            op_p1   <= NOP_INSTR[6:0];
        end else if (accept) begin
            vld_p1  <= 1'b1;
            inst_p1 <= imem_rdata_i;
            op_p1   <= imem_rdata_i[6:0];
            pc_p1   <= fetch_pc;
        end else if (vld_p1 && stall_i) begin
            vld_p1  <= vld_p1;
        end else begin
            // Previous instruction was consumed (or none) and nothing new arrived.
            vld_p1  <= 1'b0;
            inst_p1 <= NOP_INSTR;
            op_p1   <= NOP_INSTR[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_p1 <= 32'd0;
        end else if (accept) begin
            count_p1 <= count_p1 + 32'd1;
        end
    end

    assign inst_valid_o      = vld_p1;
    assign Instruction_bus_o = inst_p1;
    assign op_o              = op_p1;
    assign pc_o              = pc_p1;
    assign inst_count_o      = count_p1;
    assign fault_o           = (state == ST_FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed per-cycle stimulus pushes the
// expected instruction into a scoreboard queue; a monitor on the falling edge
// pops and compares whenever a new instruction appears in the IF/ID register.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] DC     = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] Instruction_bus_o;
    logic [6:0]  op_o;
    logic [31:0] pc_o;
    logic        fault_o;
    logic [31:0] inst_count_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    instruction_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ready_i      (imem_ready_i),
        .imem_rdata_i      (imem_rdata_i),
        .inst_valid_o      (inst_valid_o),
        .Instruction_bus_o (Instruction_bus_o),
        .op_o              (op_o),
        .pc_o              (pc_o),
        .fault_o           (fault_o),
        .inst_count_o      (inst_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, check the request,
    // and queue the expected IF/ID contents if this cycle accepts a fetch.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                        input logic rdy, input logic [31:0] rd,
                        input logic exp_req, input logic [31:0] exp_addr);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        stall_i       = s;
        redirect_i    = r;
        redirect_pc_i = rpc;
        imem_ready_i  = rdy;
        imem_rdata_i  = rd;
        #1;
        chk("imem_req", {31'd0, imem_req_o}, {31'd0, exp_req});
        chk("imem_addr", imem_addr_o, exp_addr);
        if (exp_req && rdy) begin
            exp_cnt = exp_cnt + 32'd1;
            e.pc    = exp_addr;
            e.instr = rd;
            e.cnt   = exp_cnt;
            sb_q.push_back(e);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_pc_o", pc_o, RST_PC);
        chk("rst_bus", Instruction_bus_o, NOP);
        chk("rst_op", {25'd0, op_o}, 32'h13);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_count", inst_count_o, 32'd0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, RST_PC);
    endtask

    // Monitor: a valid instruction is new unless the previous edge held it.
    initial begin
        exp_t last;
        logic held;
        held       = 1'b0;
        last.pc    = '0;
        last.instr = '0;
        last.cnt   = '0;
        forever begin
            @(negedge clk);
            if (inst_valid_o) begin
                if (!held) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr actual=%h expected=none", Instruction_bus_o);
                    end else begin
                        last = sb_q.pop_front();
                    end
                end
                chk("sb_pc", pc_o, last.pc);
                chk("sb_instr", Instruction_bus_o, last.instr);
                chk("sb_op", {25'd0, op_o}, {25'd0, last.instr[6:0]});
                chk("sb_count", inst_count_o, last.cnt);
            end else begin
                chk("bubble_bus", Instruction_bus_o, NOP);
                chk("bubble_op", {25'd0, op_o}, 32'h13);
            end
            held = inst_valid_o && stall_i && !redirect_i && !reset;
        end
    end

    initial begin
        reset         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ready_i  = 1'b0;
        imem_rdata_i  = 32'd0;
        repeat (2) @(posedge clk);
        #4;
        chk_reset_state();

        // boot cycle, then continuous fetch of four words
        step(0, 0, 0, 1, 32'h0050_0093, 0, 32'h0040_0000);
        step(0, 0, 0, 1, 32'h0050_0093, 1, 32'h0040_0000);
        step(0, 0, 0, 1, 32'h0010_0113, 1, 32'h0040_0004);
        step(0, 0, 0, 1, 32'h0020_0193, 1, 32'h0040_0008);
        step(0, 0, 0, 1, 32'h0030_0213, 1, 32'h0040_000C);
        // three-cycle stall with a valid instruction held
        step(1, 0, 0, 1, DC, 0, 32'h0040_0010);
        step(1, 0, 0, 1, DC, 0, 32'h0040_0010);
        step(1, 0, 0, 1, DC, 0, 32'h0040_0010);
        chk("stall_count", inst_count_o, 32'd4);
        step(0, 0, 0, 1, 32'h0040_A283, 1, 32'h0040_0010);
        // memory not ready for two cycles
        step(0, 0, 0, 0, DC, 1, 32'h0040_0014);
        step(0, 0, 0, 0, DC, 1, 32'h0040_0014);
        step(0, 0, 0, 1, 32'h0000_0537, 1, 32'h0040_0014);
        // redirect with concurrent stall and ready
        step(1, 1, 32'h0040_0100, 1, DC, 0, 32'h0040_0018);
        step(0, 0, 0, 1, 32'h0080_006F, 1, 32'h0040_0100);
        step(0, 0, 0, 1, 32'h0000_8067, 1, 32'h0040_0104);
        // stall with an empty register still fetches
        step(0, 0, 0, 0, DC, 1, 32'h0040_0108);
        step(1, 0, 0, 1, 32'h0011_2023, 1, 32'h0040_0108);
        step(0, 0, 0, 1, 32'h0020_8463, 1, 32'h0040_010C);
        // misaligned redirect: sticky fault, later redirect ignored
        step(0, 1, 32'h0040_0102, 1, DC, 0, 32'h0040_0110);
        step(0, 0, 0, 1, DC, 0, 32'h0040_0110);
        step(0, 1, 32'h0040_0200, 1, DC, 0, 32'h0040_0110);
        step(0, 0, 0, 1, DC, 0, 32'h0040_0110);
        chk("fault_set", {31'd0, fault_o}, 32'd1);
        chk("fault_count", inst_count_o, 32'd10);
        chk("fault_valid", {31'd0, inst_valid_o}, 32'd0);

        // reset mid-operation overrides redirect, stall and ready
        @(posedge clk);
        #1;
        reset         = 1'b1;
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0300;
        imem_ready_i  = 1'b1;
        @(posedge clk);
        #2;
        chk_reset_state();
        exp_cnt = 32'd0;
        step(0, 0, 0, 1, 32'h0050_0093, 0, 32'h0040_0000);
        step(0, 0, 0, 1, 32'h0050_0093, 1, 32'h0040_0000);
        step(0, 0, 0, 0, DC, 1, 32'h0040_0004);
        @(negedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
